// File: rtl/elevator_call_scheduler_pkg.sv
// Shared definitions for the elevator call scheduler: default sizing and FSM state encoding.
package elevator_call_scheduler_pkg;

  localparam int NUM_FLOORS_DEF = 32;
  localparam int FLOOR_W_DEF    = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_ISSUE  = 2'd2,
    S_WAIT   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/elevator_call_scheduler_if.sv
// Call/target/status bundle between the call sources, the car controller and the scheduler.
interface elevator_call_scheduler_if
  import elevator_call_scheduler_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF,
  parameter int FLOOR_W    = FLOOR_W_DEF
);

  logic                  req_valid;
  logic [FLOOR_W-1:0]    req_floor;
  logic                  req_err;
  logic [FLOOR_W-1:0]    cur_floor;
  logic                  arrived;
  logic                  tgt_valid;
  logic [FLOOR_W-1:0]    tgt_floor;
  logic                  tgt_ready;
  logic [NUM_FLOORS-1:0] pending;
  logic                  dir_up;
  logic                  busy;

  // Call sources and car side
  modport master (
    output req_valid, req_floor, cur_floor, arrived, tgt_ready,
    input  req_err, tgt_valid, tgt_floor, pending, dir_up, busy
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_floor, cur_floor, arrived, tgt_ready,
    output req_err, tgt_valid, tgt_floor, pending, dir_up, busy
  );

endinterface

// File: rtl/elevator_call_scheduler_scan_pick.sv
// SCAN target selection: nearest pending floor in the sweep direction, else reverse the sweep.
// The bit at cur_floor is never a candidate.
module elevator_call_scheduler_scan_pick #(
  parameter int NUM_FLOORS = 32,
  parameter int FLOOR_W    = 5
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  dir_up,
  output logic                  found,
  output logic [FLOOR_W-1:0]    pick_floor,
  output logic                  new_dir
);

  logic               above_found;
  logic [FLOOR_W-1:0] above_floor;
  logic               below_found;
  logic [FLOOR_W-1:0] below_floor;

  // Priority-encode the lowest pending floor above and the highest pending floor below the car
  always_comb begin
    above_found = 1'b0;
    above_floor = '0;
    below_found = 1'b0;
    below_floor = '0;
    // Descending scan: the last hit is the lowest floor above
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (FLOOR_W'(i) > cur_floor)) begin
        above_found = 1'b1;
        above_floor = FLOOR_W'(i);
      end
    end
    // Ascending scan: the last hit is the highest floor below
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (FLOOR_W'(i) < cur_floor)) begin
        below_found = 1'b1;
        below_floor = FLOOR_W'(i);
      end
    end
  end

  // Continue the current sweep if possible, otherwise turn around
  always_comb begin
    found      = above_found | below_found;
    pick_floor = '0;
    new_dir    = dir_up;
    if (dir_up) begin
      if (above_found) begin
        pick_floor = above_floor;
      end else if (below_found) begin
        pick_floor = below_floor;
        new_dir    = 1'b0;
      end
    end else begin
      if (below_found) begin
        pick_floor = below_floor;
      end else if (above_found) begin
        pick_floor = above_floor;
        new_dir    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Elevator call scheduler: accumulates floor calls in a pending bitmap and hands the car one
// target at a time following a SCAN sweep. Targets come only from registered state.
module elevator_call_scheduler
  import elevator_call_scheduler_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF,
  parameter int FLOOR_W    = FLOOR_W_DEF
) (
  input logic                       clk,
  input logic                       reset,
  elevator_call_scheduler_if.slave  bus
);

  localparam logic [FLOOR_W:0] NUM_FLOORS_W = (FLOOR_W + 1)'(NUM_FLOORS);

  sched_state_t          state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic                  dir_up_q, dir_up_d;
  logic                  tgt_valid_q, tgt_valid_d;
  logic [FLOOR_W-1:0]    tgt_floor_q, tgt_floor_d;
  logic                  req_err_q, req_err_d;

  logic [NUM_FLOORS-1:0] req_mask;
  logic [NUM_FLOORS-1:0] cur_mask;
  logic                  req_in_range;
  logic                  req_absorbed;
  logic                  pick_found;
  logic [FLOOR_W-1:0]    pick_floor;
  logic                  pick_dir;

  // One-hot of a floor index; out-of-range indices give an empty mask
  function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
    floor_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (f == FLOOR_W'(i)) floor_mask[i] = 1'b1;
    end
  endfunction

  assign req_mask     = floor_mask(bus.req_floor);
  assign cur_mask     = floor_mask(bus.cur_floor);
  assign req_in_range = ({1'b0, bus.req_floor} < NUM_FLOORS_W);
  // A call at the car's floor while idle needs no trip
  assign req_absorbed = (state_q == S_IDLE) && (bus.req_floor == bus.cur_floor);

  elevator_call_scheduler_scan_pick #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_scan_pick (
    .pending    (pending_q),
    .cur_floor  (bus.cur_floor),
    .dir_up     (dir_up_q),
    .found      (pick_found),
    .pick_floor (pick_floor),
    .new_dir    (pick_dir)
  );

  // Next-state: call capture, FSM sequencing, then arrival clear (clear has final say)
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    dir_up_d    = dir_up_q;
    tgt_valid_d = tgt_valid_q;
    tgt_floor_d = tgt_floor_q;
    req_err_d   = bus.req_valid && !req_in_range;

    if (bus.req_valid && req_in_range && !req_absorbed) begin
      pending_d = pending_d | req_mask;
    end

    case (state_q)
      S_IDLE: begin
        if (pending_q != '0) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (pick_found) begin
          tgt_floor_d = pick_floor;
          tgt_valid_d = 1'b1;
          dir_up_d    = pick_dir;
          state_d     = S_ISSUE;
        end else begin
          // Only the car's own floor (or nothing) is pending: serve it in place
          pending_d = pending_d & ~cur_mask;
          state_d   = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (bus.tgt_ready) begin
          tgt_valid_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.arrived && (bus.cur_floor == tgt_floor_q)) state_d = S_SELECT;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.arrived) begin
      pending_d = pending_d & ~cur_mask;
    end
  end

  // State registers; reset discards calls and any offered target
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      dir_up_q    <= 1'b1;
      tgt_valid_q <= 1'b0;
      tgt_floor_q <= '0;
      req_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      dir_up_q    <= dir_up_d;
      tgt_valid_q <= tgt_valid_d;
      tgt_floor_q <= tgt_floor_d;
      req_err_q   <= req_err_d;
    end
  end

  assign bus.req_err   = req_err_q;
  assign bus.tgt_valid = tgt_valid_q;
  assign bus.tgt_floor = tgt_floor_q;
  assign bus.pending   = pending_q;
  assign bus.dir_up    = dir_up_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for the elevator call scheduler: a vector table plus hand-written sequences.
module tb_elevator_call_scheduler;

  localparam int NF = 16;
  localparam int FW = 6;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  elevator_call_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bif ();

  elevator_call_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(FW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct {
    logic        rv;
    logic [5:0]  rf;
    logic [5:0]  cur;
    logic        arr;
    logic        rdy;
    logic [15:0] e_pend;
    logic        e_tv;
    logic [5:0]  e_tf;
    logic        e_dir;
    logic        e_err;
    logic        e_busy;
  } vec_t;

  vec_t tbl [21];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bif.req_valid = 1'b0;
    bif.req_floor = '0;
    bif.cur_floor = '0;
    bif.arrived   = 1'b0;
    bif.tgt_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic req(input logic [5:0] f);
    bif.req_valid = 1'b1;
    bif.req_floor = f;
    step();
    bif.req_valid = 1'b0;
  endtask

  task automatic arrive(input logic [5:0] f);
    bif.cur_floor = f;
    bif.arrived   = 1'b1;
    step();
    bif.arrived   = 1'b0;
  endtask

  task automatic wait_tv(input string nm);
    int n;
    n = 0;
    while (bif.tgt_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({nm, "_tv"}, 32'(bif.tgt_valid), 32'd1);
  endtask

  // Expect the next target and direction, accept it, then arrive there
  task automatic trip(input string nm, input logic [5:0] ef, input logic ed);
    wait_tv(nm);
    chk({nm, "_tf"}, 32'(bif.tgt_floor), 32'(ef));
    chk({nm, "_dir"}, 32'(bif.dir_up), 32'(ed));
    bif.tgt_ready = 1'b1;
    step();
    bif.tgt_ready = 1'b0;
    chk({nm, "_tv_drop"}, 32'(bif.tgt_valid), 32'd0);
    arrive(ef);
  endtask

  // Car sent to floor 2, calls 5,1,4 accumulate during the trip: WAIT with pending 0x36
  task automatic build_036();
    do_reset();
    req(6'd2);
    wait_tv("b36");
    chk("b36_tf", 32'(bif.tgt_floor), 32'd2);
    bif.tgt_ready = 1'b1;
    step();
    bif.tgt_ready = 1'b0;
    req(6'd5);
    req(6'd1);
    req(6'd4);
    chk("b36_pend", 32'(bif.pending), 32'h36);
    chk("b36_busy", 32'(bif.busy), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           rv  rf      cur     arr   rdy    pend      tv    tf      dir   err   busy
    tbl[0]  = '{1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 16'h0000, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 6'd3,  6'd0,  1'b0, 1'b0, 16'h0008, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 16'h0008, 1'b0, 6'd0,  1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 16'h0008, 1'b1, 6'd3,  1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 6'd0,  6'd0,  1'b0, 1'b1, 16'h0008, 1'b0, 6'd3,  1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 6'd0,  6'd3,  1'b1, 1'b0, 16'h0000, 1'b0, 6'd3,  1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 6'd0,  6'd3,  1'b0, 1'b0, 16'h0000, 1'b0, 6'd3,  1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 6'd2,  6'd2,  1'b1, 1'b0, 16'h0000, 1'b0, 6'd3,  1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 6'd40, 6'd2,  1'b0, 1'b0, 16'h0000, 1'b0, 6'd3,  1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 6'd0,  6'd2,  1'b0, 1'b0, 16'h0000, 1'b0, 6'd3,  1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 6'd16, 6'd2,  1'b0, 1'b0, 16'h0000, 1'b0, 6'd3,  1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 6'd15, 6'd2,  1'b0, 1'b0, 16'h8000, 1'b0, 6'd3,  1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 6'd15, 6'd2,  1'b0, 1'b0, 16'h8000, 1'b0, 6'd3,  1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 6'd0,  6'd2,  1'b0, 1'b0, 16'h8001, 1'b1, 6'd15, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 6'd0,  6'd2,  1'b0, 1'b0, 16'h8001, 1'b1, 6'd15, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 6'd0,  6'd2,  1'b0, 1'b1, 16'h8001, 1'b0, 6'd15, 1'b1, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 6'd0,  6'd15, 1'b1, 1'b0, 16'h0001, 1'b0, 6'd15, 1'b1, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 6'd0,  6'd15, 1'b0, 1'b0, 16'h0001, 1'b1, 6'd0,  1'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 6'd0,  6'd15, 1'b0, 1'b1, 16'h0001, 1'b0, 6'd0,  1'b0, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 6'd0,  6'd0,  1'b1, 1'b0, 16'h0000, 1'b0, 6'd0,  1'b0, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 16'h0000, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0};

    // Reset state
    do_reset();
    chk("rst_pend", 32'(bif.pending), 32'h0);
    chk("rst_tv", 32'(bif.tgt_valid), 32'd0);
    chk("rst_tf", 32'(bif.tgt_floor), 32'd0);
    chk("rst_dir", 32'(bif.dir_up), 32'd1);
    chk("rst_err", 32'(bif.req_err), 32'd0);
    chk("rst_busy", 32'(bif.busy), 32'd0);

    // Vector table: first call latency, absorb, out-of-range, duplicate, top/bottom sweep flip
    for (int i = 0; i < 21; i++) begin
      bif.req_valid = tbl[i].rv;
      bif.req_floor = tbl[i].rf;
      bif.cur_floor = tbl[i].cur;
      bif.arrived   = tbl[i].arr;
      bif.tgt_ready = tbl[i].rdy;
      step();
      chk($sformatf("v%0d_pend", i), 32'(bif.pending), 32'(tbl[i].e_pend));
      chk($sformatf("v%0d_tv", i), 32'(bif.tgt_valid), 32'(tbl[i].e_tv));
      chk($sformatf("v%0d_tf", i), 32'(bif.tgt_floor), 32'(tbl[i].e_tf));
      chk($sformatf("v%0d_dir", i), 32'(bif.dir_up), 32'(tbl[i].e_dir));
      chk($sformatf("v%0d_err", i), 32'(bif.req_err), 32'(tbl[i].e_err));
      chk($sformatf("v%0d_busy", i), 32'(bif.busy), 32'(tbl[i].e_busy));
    end
    bif.req_valid = 1'b0;
    bif.arrived   = 1'b0;
    bif.tgt_ready = 1'b0;

    // SCAN order: from floor 2 going up, calls 1,4,5 are served 4,5,1
    build_036();
    arrive(6'd2);
    chk("s2_pend", 32'(bif.pending), 32'h32);
    trip("s2a", 6'd4, 1'b1);
    trip("s2b", 6'd5, 1'b1);
    trip("s2c", 6'd1, 1'b0);
    step();
    chk("s2_idle", 32'(bif.busy), 32'd0);
    chk("s2_pend0", 32'(bif.pending), 32'h0);

    // Target held stable under back-pressure, transferred exactly once
    do_reset();
    req(6'd7);
    wait_tv("s3");
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("s3_hold_tv%0d", i), 32'(bif.tgt_valid), 32'd1);
      chk($sformatf("s3_hold_tf%0d", i), 32'(bif.tgt_floor), 32'd7);
    end
    bif.tgt_ready = 1'b1;
    step();
    bif.tgt_ready = 1'b0;
    chk("s3_xfer_tv", 32'(bif.tgt_valid), 32'd0);
    step();
    chk("s3_once_tv", 32'(bif.tgt_valid), 32'd0);
    chk("s3_wait_busy", 32'(bif.busy), 32'd1);
    // Arrival clear beats a same-cycle call; non-target arrival clears only its own bit
    req(6'd3);
    chk("s4_pend88", 32'(bif.pending), 32'h88);
    bif.req_valid = 1'b1;
    bif.req_floor = 6'd2;
    arrive(6'd2);
    bif.req_valid = 1'b0;
    chk("s4_clrwins", 32'(bif.pending), 32'h88);
    arrive(6'd3);
    chk("s4_nontgt", 32'(bif.pending), 32'h80);
    chk("s4_still_wait", 32'(bif.busy), 32'd1);
    arrive(6'd7);
    chk("s4_pend0", 32'(bif.pending), 32'h0);
    step();
    chk("s4_idle", 32'(bif.busy), 32'd0);

    // Call at the car's floor during a trip is served next, after a direction flip
    do_reset();
    bif.cur_floor = 6'd4;
    req(6'd6);
    wait_tv("s5");
    chk("s5_tf6", 32'(bif.tgt_floor), 32'd6);
    bif.tgt_ready = 1'b1;
    step();
    bif.tgt_ready = 1'b0;
    req(6'd4);
    chk("s5_pend50", 32'(bif.pending), 32'h50);
    arrive(6'd6);
    chk("s5_pend10", 32'(bif.pending), 32'h10);
    trip("s5b", 6'd4, 1'b0);
    step();
    chk("s5_idle", 32'(bif.busy), 32'd0);
    chk("s5_pend0", 32'(bif.pending), 32'h0);

    // Only the car's own floor pending at SELECT: cleared in place, no target
    bif.cur_floor = 6'd0;
    req(6'd5);
    chk("s5c_pend", 32'(bif.pending), 32'h20);
    bif.cur_floor = 6'd5;
    step();
    chk("s5c_sel_busy", 32'(bif.busy), 32'd1);
    step();
    chk("s5c_pend0", 32'(bif.pending), 32'h0);
    chk("s5c_busy0", 32'(bif.busy), 32'd0);
    chk("s5c_tv0", 32'(bif.tgt_valid), 32'd0);

    // Reset in WAIT with calls outstanding
    build_036();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("s6_pend", 32'(bif.pending), 32'h0);
    chk("s6_tv", 32'(bif.tgt_valid), 32'd0);
    chk("s6_busy", 32'(bif.busy), 32'd0);
    chk("s6_dir", 32'(bif.dir_up), 32'd1);

    // Reset while a target is being offered
    req(6'd9);
    wait_tv("s6b");
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("s6b_tv", 32'(bif.tgt_valid), 32'd0);
    chk("s6b_tf", 32'(bif.tgt_floor), 32'd0);
    chk("s6b_pend", 32'(bif.pending), 32'h0);
    chk("s6b_busy", 32'(bif.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
